// File: rtl/systolic_feeder.sv
// Input skew/staging stage for an NxN systolic array: lane i is delayed i advance steps.
// Optional build macro FEEDER_STALL_CNT_EN adds the stall_cnt output.

module feeder_lane #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  // pipe[0] takes the new step; pipe[DEPTH] is the output register
  logic [DEPTH:0][W-1:0] pipe;

  if (DEPTH == 0) begin : g_d0
    always_ff @(posedge clk) begin
      if (rst)      pipe <= '0;
      else if (adv) pipe <= din;
    end
  end else begin : g_dn
    always_ff @(posedge clk) begin
      if (rst)      pipe <= '0;
      else if (adv) pipe <= {pipe[DEPTH-1:0], din};
    end
  end

  assign dout = pipe[DEPTH];
endmodule

module systolic_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KW         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_col,
  input  logic [N*DATA_WIDTH-1:0] b_row,
  output logic [N*DATA_WIDTH-1:0] a_out,
  output logic [N*DATA_WIDTH-1:0] b_out,
  output logic                    we,
  output logic                    busy,
  output logic                    done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);
  localparam int DRAIN_LEN = 2*N - 2;
  localparam int CW        = (N > 1) ? $clog2(2*N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   beat_cnt, beat_nx;
  logic [CW-1:0]   drain_cnt, drain_nx;
  logic            adv;

  logic [N-1:0][DATA_WIDTH-1:0] a_in, b_in, a_q, b_q;

  always_comb begin
    state_nx = state;
    beat_nx  = beat_cnt;
    drain_nx = drain_cnt;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_nx = STREAM;
            beat_nx  = k_len;
          end else begin
            state_nx = FIN;
          end
        end
      end
      STREAM: begin
        if (in_valid) begin
          adv     = 1'b1;
          beat_nx = beat_cnt - KW'(1);
          if (beat_cnt == KW'(1)) begin
            drain_nx = CW'(DRAIN_LEN);
            state_nx = (DRAIN_LEN == 0) ? FIN : DRAIN;
          end
        end
      end
      DRAIN: begin
        adv      = 1'b1;
        drain_nx = drain_cnt - CW'(1);
        if (drain_cnt <= CW'(1)) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      we        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      beat_cnt  <= beat_nx;
      drain_cnt <= drain_nx;
      we        <= adv;
      done      <= (state == FIN);
    end
  end

  assign in_ready = (state == STREAM);
  assign busy     = (state != IDLE);

  // DRAIN flushes the skew chains with zero operands
  assign a_in = (state == STREAM) ? a_col : '0;
  assign b_in = (state == STREAM) ? b_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(.DEPTH(i), .W(DATA_WIDTH)) u_a (
      .clk(clk), .rst(rst), .adv(adv), .din(a_in[i]), .dout(a_q[i])
    );
    feeder_lane #(.DEPTH(i), .W(DATA_WIDTH)) u_b (
      .clk(clk), .rst(rst), .adv(adv), .din(b_in[i]), .dout(b_q[i])
    );
  end

  assign a_out = a_q;
  assign b_out = b_q;

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (state == STREAM && !in_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: cycle table for the K=1 skew plus job sequences
// checked against a behavioural 4x4 array and the skew formula.

module tb_systolic_feeder;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, we, busy, done;
  logic [7:0]  k_len;
  logic [31:0] a_col, b_row, a_out, b_out;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  systolic_feeder #(.N(4), .DATA_WIDTH(8), .KW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .a_out(a_out), .b_out(b_out),
    .we(we), .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ma[r][k] = A[r][k], mb[k][c] = B[k][c]
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  function automatic logic [31:0] beat_a(input int k);
    logic [31:0] v;
    for (int r = 0; r < N; r++) v[r*8 +: 8] = ma[r][k];
    return v;
  endfunction

  function automatic logic [31:0] beat_b(input int k);
    logic [31:0] v;
    for (int c = 0; c < N; c++) v[c*8 +: 8] = mb[k][c];
    return v;
  endfunction

  // Behavioural PE array plus activity monitors
  logic        model_clr = 1'b0;
  logic [7:0]  pa [4][4];
  logic [7:0]  pb [4][4];
  int          acc [4][4];
  int          we_cnt, done_cnt, acc_cnt;
  logic [31:0] cap_a[$];
  logic [31:0] cap_b[$];

  always @(posedge clk) begin
    logic [7:0] ain, bin;
    if (model_clr) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pa[r][c] <= '0; pb[r][c] <= '0; acc[r][c] <= 0;
        end
      we_cnt <= 0; done_cnt <= 0; acc_cnt <= 0;
      cap_a.delete(); cap_b.delete();
    end else begin
      if (we) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ain = (c == 0) ? a_out[r*8 +: 8] : pa[r][c-1];
            bin = (r == 0) ? b_out[c*8 +: 8] : pb[r-1][c];
            acc[r][c] <= acc[r][c] + int'(ain) * int'(bin);
            pa[r][c]  <= ain;
            pb[r][c]  <= bin;
          end
        we_cnt <= we_cnt + 1;
        cap_a.push_back(a_out);
        cap_b.push_back(b_out);
      end
      if (done)               done_cnt <= done_cnt + 1;
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic clear_model;
    model_clr = 1'b1;
    tick;
    model_clr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick;
      if (done) seen = 1;
    end
    if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    tick;
    tick;
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_job(input string nm, input int k, input int stall_len, input bit extra_start);
    int  b = 0;
    int  guard = 0;
    bit  stalled = 0;
    logic rdy;
    clear_model;
    start = 1'b1; k_len = 8'(k); in_valid = 1'b0;
    tick;
    start = 1'b0;
    while (b < k && guard < 200) begin
      guard++;
      if (b == 1 && !stalled && stall_len > 0) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick;
          chk({nm, "_stall_we"},  {31'd0, we},       32'd0);
          chk({nm, "_stall_rdy"}, {31'd0, in_ready}, 32'd1);
        end
        stalled = 1;
      end else begin
        in_valid = 1'b1; a_col = beat_a(b); b_row = beat_b(b);
        if (extra_start && b == 1) begin start = 1'b1; k_len = 8'd9; end
        rdy = in_ready;
        tick;
        start = 1'b0;
        if (rdy) b++;
      end
    end
    in_valid = 1'b0;
    wait_done(nm);
  endtask

  task automatic check_job(input string nm, input int k);
    int steps = k + 2*N - 2;
    logic [31:0] ea, eb;
    int e;
    chk({nm, "_we_pulses"}, 32'(we_cnt),   32'(steps));
    chk({nm, "_beats"},     32'(acc_cnt),  32'(k));
    chk({nm, "_done_cnt"},  32'(done_cnt), 32'd1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e = 0;
        for (int kk = 0; kk < k; kk++) e += int'(ma[r][kk]) * int'(mb[kk][c]);
        chk($sformatf("%s_c%0d%0d", nm, r, c), 32'(acc[r][c]), 32'(e));
      end
    if (cap_a.size() == steps) begin
      for (int t = 0; t < steps; t++) begin
        ea = '0; eb = '0;
        for (int i = 0; i < N; i++)
          if (t - i >= 0 && t - i < k) begin
            ea[i*8 +: 8] = ma[i][t-i];
            eb[i*8 +: 8] = mb[t-i][i];
          end
        chk($sformatf("%s_a_step%0d", nm, t), cap_a[t], ea);
        chk($sformatf("%s_b_step%0d", nm, t), cap_b[t], eb);
      end
    end
  endtask

  typedef struct {
    logic        st;
    logic [7:0]  kl;
    logic        vl;
    logic [31:0] a, b;
    logic        ewe;
    logic [31:0] ea, eb;
    logic        erdy, ebusy, edone;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{1'b1, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    tv[1] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h00000001, 32'h00000005, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h00000200, 32'h00000600, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h00030000, 32'h00070000, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h04000000, 32'h08000000, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    tv[8] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
    tv[9] = '{1'b0, 8'd1, 1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;
    model_clr = 1'b1;
    tick; tick; tick;
    model_clr = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",       {31'd0, we},       32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_a_out",    a_out, 32'd0);
    chk("rst_b_out",    b_out, 32'd0);
    rst = 1'b0;
    tick;

    // K=1 skew, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      start = tv[i].st; k_len = tv[i].kl; in_valid = tv[i].vl;
      a_col = tv[i].a;  b_row = tv[i].b;
      tick;
      chk($sformatf("k1_we_%0d", i),    {31'd0, we},       {31'd0, tv[i].ewe});
      chk($sformatf("k1_a_%0d", i),     a_out,             tv[i].ea);
      chk($sformatf("k1_b_%0d", i),     b_out,             tv[i].eb);
      chk($sformatf("k1_rdy_%0d", i),   {31'd0, in_ready}, {31'd0, tv[i].erdy});
      chk($sformatf("k1_busy_%0d", i),  {31'd0, busy},     {31'd0, tv[i].ebusy});
      chk($sformatf("k1_done_%0d", i),  {31'd0, done},     {31'd0, tv[i].edone});
    end
    start = 1'b0; in_valid = 1'b0;
    tick;

    // identity x identity
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = (r == c) ? 8'd1 : 8'd0;
      end
    run_job("ident", 4, 0, 1'b0);
    check_job("ident", 4);
`ifdef FEEDER_STALL_CNT_EN
    chk("ident_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

    // general matrices with a 3-cycle stall after the first beat
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 8'(r*4 + c + 1);
        mb[r][c] = 8'(3*r + 2*c + 5);
      end
    run_job("stall", 4, 3, 1'b0);
    check_job("stall", 4);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // k_len = 0
    clear_model;
    start = 1'b1; k_len = 8'd0;
    tick;
    start = 1'b0;
    chk("k0_rdy0",  {31'd0, in_ready}, 32'd0);
    chk("k0_busy0", {31'd0, busy},     32'd1);
    chk("k0_done0", {31'd0, done},     32'd0);
    tick;
    chk("k0_done1", {31'd0, done},     32'd1);
    chk("k0_rdy1",  {31'd0, in_ready}, 32'd0);
    tick;
    chk("k0_done2", {31'd0, done},     32'd0);
    tick;
    chk("k0_we_pulses", 32'(we_cnt), 32'd0);

    // reset while draining
    clear_model;
    start = 1'b1; k_len = 8'd2;
    tick;
    start = 1'b0;
    in_valid = 1'b1; a_col = beat_a(0); b_row = beat_b(0);
    tick;
    a_col = beat_a(1); b_row = beat_b(1);
    tick;
    in_valid = 1'b0;
    tick;
    chk("drain_rdy", {31'd0, in_ready}, 32'd0);
    chk("drain_we",  {31'd0, we},       32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we",   {31'd0, we},   32'd0);
    chk("abort_a",    a_out,         32'd0);
    chk("abort_b",    b_out,         32'd0);
    for (int i = 0; i < 20; i++) tick;
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_job("post_rst", 2, 0, 1'b0);
    check_job("post_rst", 2);

    // second start mid-stream is ignored
    run_job("restart", 3, 0, 1'b1);
    check_job("restart", 3);
`ifdef FEEDER_STALL_CNT_EN
    chk("restart_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
